// File: rtl/i2c_pkg.sv
// i2c_pkg: definitions shared by the I2C slave endpoint and the I2C master driver.
//   BYTE_BITS / ADDR_BITS : bus byte and address widths
//   slave_state_e         : slave protocol state
package i2c_pkg;

  localparam int BYTE_BITS = 8;
  localparam int ADDR_BITS = 7;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    WRITE     = 4'd3,
    WRITE_ACK = 4'd4,
    READ_REQ  = 4'd5,
    READ      = 4'd6,
    READ_ACK  = 4'd7,
    IGNORE    = 4'd8
  } slave_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: conditions one open-drain bus line.
//   clk_i, rst_ni : logic clock, async active-low reset
//   line_i        : raw pin value
//   level_o       : filtered line level (resets to 1)
//   rise_o/fall_o : one-cycle strobes, aligned with the level_o change
// Pin-to-strobe latency is 2 + FILTER_LEN + 1 clk cycles. FILTER_LEN must be >= 2.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0]            sync_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic                  level_q;
  logic                  rise_q;
  logic                  fall_q;
  logic                  all_high_s;
  logic                  all_low_s;

  assign all_high_s = &hist_q;
  assign all_low_s  = ~|hist_q;

  // Synchronizer, sample history, filtered level and edge strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      hist_q  <= '1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      hist_q <= {hist_q[FILTER_LEN-2:0], sync_q[1]};
      rise_q <= all_high_s & ~level_q;
      fall_q <= all_low_s & level_q;
      if (all_high_s) begin
        level_q <= 1'b1;
      end else if (all_low_s) begin
        level_q <= 1'b0;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target endpoint answering one 7-bit address.
//   clk, rstN            : logic clock, async active-low reset
//   scl, sda             : open-drain bus lines (driven 0 or z)
//   dIn/dInValid         : read byte from fabric, taken while dInRequest is high
//   dInRequest           : waiting for a read byte (SCL stretched meanwhile)
//   sendAck              : ACK(1)/NACK(0) for the current written byte
//   dOut/dOutStrobe      : last written byte and its update pulse
//   readNWrite           : R/W bit of the addressed transfer
//   startStrobe/stopStrobe, recvAck, busy : transfer status
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h42,
  parameter int         FILTER_LEN    = 3,
  parameter int         HOLD_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rstN,
  inout  wire        scl,
  inout  wire        sda,
  input  logic [7:0] dIn,
  input  logic       dInValid,
  output logic       dInRequest,
  input  logic       sendAck,
  output logic [7:0] dOut,
  output logic       dOutStrobe,
  output logic       readNWrite,
  output logic       startStrobe,
  output logic       stopStrobe,
  output logic       recvAck,
  output logic       busy
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES);
  localparam logic [3:0] LAST_BIT  = 4'(BYTE_BITS - 1);
  localparam logic [3:0] ALL_BITS  = 4'(BYTE_BITS);

  logic scl_lvl_s, scl_rise_s, scl_fall_s;
  logic sda_lvl_s, sda_rise_s, sda_fall_s;
  logic start_s, stop_s, hold_fire_s;

  slave_state_e         state_q;
  logic [3:0]           bit_cnt_q;
  logic [ADDR_BITS-1:0] shift_q;
  logic [6:0]           tx_q;
  logic [7:0]           hold_cnt_q;
  logic                 ack_phase_q, ack_q;
  logic                 scl_low_q, sda_low_q;
  logic [7:0]           dout_q;
  logic                 dout_strobe_q, start_strobe_q, stop_strobe_q;
  logic                 din_req_q, rnw_q, recv_ack_q, busy_q;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk_i(clk), .rst_ni(rstN), .line_i(scl),
    .level_o(scl_lvl_s), .rise_o(scl_rise_s), .fall_o(scl_fall_s)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk_i(clk), .rst_ni(rstN), .line_i(sda),
    .level_o(sda_lvl_s), .rise_o(sda_rise_s), .fall_o(sda_fall_s)
  );

  assign start_s     = sda_fall_s & scl_lvl_s;
  assign stop_s      = sda_rise_s & scl_lvl_s;
  // Last cycle of the hold window; the SDA change lands on the following edge.
  assign hold_fire_s = (hold_cnt_q == 8'd1);

  // Protocol FSM with all bus drives and outputs registered.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q        <= IDLE;
      bit_cnt_q      <= 4'd0;
      shift_q        <= '0;
      tx_q           <= 7'd0;
      hold_cnt_q     <= 8'd0;
      ack_phase_q    <= 1'b0;
      ack_q          <= 1'b0;
      scl_low_q      <= 1'b0;
      sda_low_q      <= 1'b0;
      dout_q         <= 8'd0;
      dout_strobe_q  <= 1'b0;
      start_strobe_q <= 1'b0;
      stop_strobe_q  <= 1'b0;
      din_req_q      <= 1'b0;
      rnw_q          <= 1'b0;
      recv_ack_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      dout_strobe_q  <= 1'b0;
      start_strobe_q <= 1'b0;
      stop_strobe_q  <= 1'b0;
      if (scl_fall_s) begin
        hold_cnt_q <= HOLD_LOAD;
      end else if (hold_cnt_q != 8'd0) begin
        hold_cnt_q <= hold_cnt_q - 8'd1;
      end

      if (start_s) begin
        state_q   <= ADDR;
        bit_cnt_q <= 4'd0;
        scl_low_q <= 1'b0;
        sda_low_q <= 1'b0;
        din_req_q <= 1'b0;
      end else if (stop_s) begin
        state_q       <= IDLE;
        scl_low_q     <= 1'b0;
        sda_low_q     <= 1'b0;
        din_req_q     <= 1'b0;
        stop_strobe_q <= busy_q;
        busy_q        <= 1'b0;
      end else begin
        case (state_q)
          ADDR: begin
            if (scl_rise_s) begin
              shift_q   <= {shift_q[ADDR_BITS-2:0], sda_lvl_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == LAST_BIT) begin
                // shift_q now holds the 7 address bits; SDA carries R/W.
                if (shift_q == SLAVE_ADDRESS) begin
                  rnw_q       <= sda_lvl_s;
                  ack_phase_q <= 1'b0;
                  state_q     <= ADDR_ACK;
                end else begin
                  busy_q  <= 1'b0;
                  state_q <= IGNORE;
                end
              end
            end
          end
          // Phase 0 drives the ACK level after the hold; phase 1 releases it one SCL period later.
          ADDR_ACK, WRITE_ACK: begin
            if (hold_fire_s) begin
              if (!ack_phase_q) begin
                sda_low_q   <= (state_q == ADDR_ACK) ? 1'b1 : ack_q;
                ack_phase_q <= 1'b1;
              end else begin
                sda_low_q   <= 1'b0;
                ack_phase_q <= 1'b0;
                bit_cnt_q   <= 4'd0;
                if (state_q == WRITE_ACK) begin
                  state_q <= WRITE;
                end else begin
                  start_strobe_q <= 1'b1;
                  busy_q         <= 1'b1;
                  if (rnw_q) begin
                    state_q   <= READ_REQ;
                    scl_low_q <= 1'b1;
                    din_req_q <= 1'b1;
                  end else begin
                    state_q <= WRITE;
                  end
                end
              end
            end
          end
          WRITE: begin
            if (scl_rise_s && (bit_cnt_q != ALL_BITS)) begin
              shift_q   <= {shift_q[ADDR_BITS-2:0], sda_lvl_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == LAST_BIT) begin
                dout_q        <= {shift_q, sda_lvl_s};
                dout_strobe_q <= 1'b1;
              end
            end else if (scl_fall_s && (bit_cnt_q == ALL_BITS)) begin
              ack_q       <= sendAck;
              ack_phase_q <= 1'b0;
              state_q     <= WRITE_ACK;
            end
          end
          READ_REQ: begin
            if (din_req_q && dInValid) begin
              // MSB goes out now; SCL is released only after a full hold time.
              tx_q       <= dIn[6:0];
              sda_low_q  <= ~dIn[7];
              din_req_q  <= 1'b0;
              hold_cnt_q <= HOLD_LOAD;
            end else if (!din_req_q && hold_fire_s) begin
              scl_low_q <= 1'b0;
              bit_cnt_q <= 4'd0;
              state_q   <= READ;
            end
          end
          READ: begin
            if (hold_fire_s) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == LAST_BIT) begin
                sda_low_q <= 1'b0;
                state_q   <= READ_ACK;
              end else begin
                sda_low_q <= ~tx_q[6];
                tx_q      <= {tx_q[5:0], 1'b0};
              end
            end
          end
          READ_ACK: begin
            if (scl_rise_s) begin
              recv_ack_q <= ~sda_lvl_s;
            end else if (scl_fall_s) begin
              if (recv_ack_q) begin
                state_q   <= READ_REQ;
                scl_low_q <= 1'b1;
                din_req_q <= 1'b1;
              end else begin
                busy_q  <= 1'b0;
                state_q <= IGNORE;
              end
            end
          end
          IDLE, IGNORE: begin
            scl_low_q <= 1'b0;
            sda_low_q <= 1'b0;
          end
          default: begin
            state_q   <= IDLE;
            scl_low_q <= 1'b0;
            sda_low_q <= 1'b0;
            din_req_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign scl         = scl_low_q ? 1'b0 : 1'bz;
  assign sda         = sda_low_q ? 1'b0 : 1'bz;
  assign dInRequest  = din_req_q;
  assign dOut        = dout_q;
  assign dOutStrobe  = dout_strobe_q;
  assign readNWrite  = rnw_q;
  assign startStrobe = start_strobe_q;
  assign stopStrobe  = stop_strobe_q;
  assign recvAck     = recv_ack_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bench acting as bus master and fabric for i2c_slave.
module tb_i2c_slave;
  localparam int         Q          = 25;      // quarter SCL period in clk cycles
  localparam logic [6:0] SLAVE_ADDR = 7'h42;
  localparam int         FILTER_LEN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN = 1'b0;
  logic [7:0] dIn = 8'd0;
  logic       dInValid = 1'b0, sendAck = 1'b1;
  logic       dInRequest, dOutStrobe, readNWrite, startStrobe, stopStrobe, recvAck, busy;
  logic [7:0] dOut;
  logic       m_scl_low = 1'b0, m_sda_low = 1'b0;
  wire        scl_w, sda_w;

  pullup (scl_w);
  pullup (sda_w);
  assign scl_w = m_scl_low ? 1'b0 : 1'bz;
  assign sda_w = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave dut (
    .clk(clk), .rstN(rstN), .scl(scl_w), .sda(sda_w),
    .dIn(dIn), .dInValid(dInValid), .dInRequest(dInRequest), .sendAck(sendAck),
    .dOut(dOut), .dOutStrobe(dOutStrobe), .readNWrite(readNWrite),
    .startStrobe(startStrobe), .stopStrobe(stopStrobe), .recvAck(recvAck), .busy(busy)
  );

  int vectors = 0, miscompares = 0;
  int n_start = 0, n_stop = 0, n_dout = 0, n_slave_sda = 0;
  int scl_low_run = 0, scl_low_max = 0, clr_epoch = 0, seen_epoch = 0;
  logic [7:0] last_dout = 8'd0;

  // Event monitor: strobe counts, slave-driven SDA, longest SCL low period.
  always @(negedge clk) begin
    if (startStrobe) n_start <= n_start + 1;
    if (stopStrobe) n_stop <= n_stop + 1;
    if (dOutStrobe) begin n_dout <= n_dout + 1; last_dout <= dOut; end
    if (sda_w === 1'b0 && !m_sda_low) n_slave_sda <= n_slave_sda + 1;
    if (seen_epoch != clr_epoch) begin
      seen_epoch <= clr_epoch; scl_low_max <= 0; scl_low_run <= 0;
    end else if (scl_w === 1'b0) begin
      scl_low_run <= scl_low_run + 1;
      if (scl_low_run + 1 > scl_low_max) scl_low_max <= scl_low_run + 1;
    end else begin
      scl_low_run <= 0;
    end
  end

  // Reference model: the slave ACKs an address byte whose upper 7 bits match.
  function automatic logic model_addr_ack(input logic [7:0] a);
    return a[7:1] == SLAVE_ADDR;
  endfunction

  task automatic clks(input int n); repeat (n) @(negedge clk); endtask

  task automatic release_scl();
    int t = 0;
    m_scl_low = 1'b0;
    while (scl_w !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
    if (scl_w !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL scl_release: scl=%b after %0d cycles, required 1", scl_w, t);
    end
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; clks(Q); release_scl(); clks(Q);
    m_sda_low = 1'b1; clks(Q); m_scl_low = 1'b1; clks(Q);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; clks(Q); release_scl(); clks(Q);
    m_sda_low = 1'b0; clks(2 * Q);
  endtask

  task automatic wr_bit(input logic b, input logic glitch);
    m_sda_low = !b; clks(Q); release_scl(); clks(Q);
    if (glitch) begin m_sda_low = 1'b1; clks(FILTER_LEN - 1); m_sda_low = 1'b0; clks(Q - FILTER_LEN + 1); end
    else clks(Q);
    m_scl_low = 1'b1; clks(Q);
  endtask

  task automatic rd_bit(output logic b);
    m_sda_low = 1'b0; clks(Q); release_scl(); clks(Q);
    b = sda_w; clks(Q); m_scl_low = 1'b1; clks(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, input int glitch_bit, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) wr_bit(d[i], i == glitch_bit);
    rd_bit(b);
    acked = !b;
  endtask

  task automatic rd_byte(input logic ack, output logic [7:0] d);
    logic [7:0] v;
    logic b;
    for (int i = 7; i >= 0; i--) begin rd_bit(b); v[i] = b; end
    wr_bit(!ack, 1'b0);
    d = v;
  endtask

  task automatic fabric(input int delay, input logic [7:0] v);
    int t = 0;
    while (dInRequest !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
    vectors++;
    if (dInRequest !== 1'b1) begin miscompares++; $display("FAIL din_request: got %b, required 1", dInRequest); end
    clks(delay);
    dIn = v; dInValid = 1'b1; t = 0;
    while (dInRequest === 1'b1 && t < 100) begin @(negedge clk); t++; end
    dInValid = 1'b0;
  endtask

  task automatic test_reset();
    clks(5); rstN = 1'b1; clks(10);
    vectors++; if (dOut !== 8'h00) begin miscompares++; $display("FAIL rst_dout: got %h, required 00", dOut); end
    vectors++; if ({dInRequest, dOutStrobe, readNWrite, startStrobe, stopStrobe, recvAck, busy} !== 7'd0) begin
      miscompares++; $display("FAIL rst_flags: got %b, required 0000000",
        {dInRequest, dOutStrobe, readNWrite, startStrobe, stopStrobe, recvAck, busy}); end
    vectors++; if ({scl_w, sda_w} !== 2'b11) begin miscompares++; $display("FAIL rst_lines: got %b, required 11", {scl_w, sda_w}); end
  endtask

  task automatic test_write();
    int s0 = n_start, p0 = n_stop, d0 = n_dout;
    logic a1, a2;
    sendAck = 1'b1;
    bus_start(); wr_byte(8'h84, -1, a1); wr_byte(8'hA5, -1, a2);
    vectors++; if ({a1, a2} !== 2'b11) begin miscompares++; $display("FAIL wr_acks: got %b, required 11", {a1, a2}); end
    vectors++; if (busy !== 1'b1 || readNWrite !== 1'b0) begin miscompares++; $display("FAIL wr_busy_rnw: got %b%b, required 10", busy, readNWrite); end
    bus_stop();
    vectors++; if (n_start - s0 != 1 || n_dout - d0 != 1 || n_stop - p0 != 1) begin miscompares++;
      $display("FAIL wr_strobes: start/dout/stop got %0d/%0d/%0d, required 1/1/1", n_start - s0, n_dout - d0, n_stop - p0); end
    vectors++; if (last_dout !== 8'hA5) begin miscompares++; $display("FAIL wr_dout: got %h, required a5", last_dout); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL wr_busy_end: got %b, required 0", busy); end
  endtask

  task automatic test_bad_address();
    int s0 = n_start, d0 = n_dout, x0 = n_slave_sda;
    logic a1, a2, busy_seen;
    bus_start(); wr_byte(8'h86, -1, a1); busy_seen = busy; wr_byte(8'h5A, -1, a2); busy_seen |= busy; bus_stop();
    vectors++; if ({a1, a2} !== 2'b00) begin miscompares++; $display("FAIL bad_acks: got %b, required 00", {a1, a2}); end
    vectors++; if (n_slave_sda != x0) begin miscompares++; $display("FAIL bad_sda: slave drove SDA %0d cycles, required 0", n_slave_sda - x0); end
    vectors++; if (busy_seen !== 1'b0 || n_start != s0 || n_dout != d0) begin miscompares++;
      $display("FAIL bad_status: busy=%b start=%0d dout=%0d, required 0/0/0", busy_seen, n_start - s0, n_dout - d0); end
  endtask

  task automatic test_read_nack();
    logic a1;
    logic [7:0] d;
    clr_epoch++;
    bus_start(); wr_byte(8'h85, -1, a1);
    vectors++; if (a1 !== 1'b1) begin miscompares++; $display("FAIL rd_addr_ack: got %b, required 1", a1); end
    fork
      fabric(50, 8'h3C);
      rd_byte(1'b0, d);
    join
    vectors++; if (d !== 8'h3C) begin miscompares++; $display("FAIL rd_data: got %h, required 3c", d); end
    // Low time must cover the 50-cycle fabric delay plus request and hold latency.
    vectors++; if (scl_low_max < 60) begin miscompares++; $display("FAIL rd_stretch: got %0d cycles, required >= 60", scl_low_max); end
    vectors++; if ({recvAck, busy, sda_w} !== 3'b001) begin miscompares++; $display("FAIL rd_nack_state: got %b, required 001", {recvAck, busy, sda_w}); end
    bus_stop();
  endtask

  task automatic test_write_nack();
    int d0 = n_dout;
    logic a1, a2;
    sendAck = 1'b0;
    bus_start(); wr_byte(8'h84, -1, a1); wr_byte(8'h11, -1, a2); bus_stop();
    sendAck = 1'b1;
    vectors++; if ({a1, a2} !== 2'b10) begin miscompares++; $display("FAIL wn_acks: got %b, required 10", {a1, a2}); end
    vectors++; if (n_dout - d0 != 1 || last_dout !== 8'h11) begin miscompares++; $display("FAIL wn_dout: got %0d x %h, required 1 x 11", n_dout - d0, last_dout); end
  endtask

  task automatic test_restart_read();
    int s0 = n_start, p0 = n_stop;
    logic a1, a2, a3;
    logic [7:0] d;
    bus_start(); wr_byte(8'h84, -1, a1); wr_byte(8'h22, -1, a2);
    vectors++; if (readNWrite !== 1'b0) begin miscompares++; $display("FAIL rs_rnw0: got %b, required 0", readNWrite); end
    bus_start(); wr_byte(8'h85, -1, a3);
    vectors++; if ({a1, a2, a3} !== 3'b111 || readNWrite !== 1'b1) begin miscompares++;
      $display("FAIL rs_acks_rnw: got %b/%b, required 111/1", {a1, a2, a3}, readNWrite); end
    fork
      fabric($urandom_range(0, 20), 8'h7E);
      rd_byte(1'b1, d);
    join
    vectors++; if (d !== 8'h7E) begin miscompares++; $display("FAIL rs_data: got %h, required 7e", d); end
    vectors++; if ({recvAck, dInRequest} !== 2'b11) begin miscompares++; $display("FAIL rs_ack_req: got %b, required 11", {recvAck, dInRequest}); end
    fork
      bus_stop();
      fabric(0, 8'hFF);
    join
    vectors++; if (n_start - s0 != 2 || n_stop - p0 != 1 || busy !== 1'b0) begin miscompares++;
      $display("FAIL rs_strobes: start=%0d stop=%0d busy=%b, required 2/1/0", n_start - s0, n_stop - p0, busy); end
  endtask

  task automatic test_reset_mid_stretch();
    int s0, p0;
    logic a1, a2;
    bus_start(); wr_byte(8'h85, -1, a1);
    m_sda_low = 1'b0; clks(Q); m_scl_low = 1'b0; clks(20);
    vectors++; if ({scl_w, dInRequest} !== 2'b01) begin miscompares++; $display("FAIL rm_stretch: scl/req got %b, required 01", {scl_w, dInRequest}); end
    rstN = 1'b0; #1;
    vectors++; if ({scl_w, sda_w} !== 2'b11) begin miscompares++; $display("FAIL rm_lines: got %b, required 11", {scl_w, sda_w}); end
    vectors++; if ({dOut, dInRequest, dOutStrobe, readNWrite, startStrobe, stopStrobe, recvAck, busy} !== 15'd0) begin miscompares++;
      $display("FAIL rm_outputs: got %h, required 0000", {dOut, dInRequest, dOutStrobe, readNWrite, startStrobe, stopStrobe, recvAck, busy}); end
    clks(3); rstN = 1'b1; clks(10);
    s0 = n_start; p0 = n_stop; sendAck = 1'b1;
    bus_start(); wr_byte(8'h84, -1, a1); wr_byte(8'h5A, -1, a2); bus_stop();
    vectors++; if ({a1, a2} !== 2'b11 || last_dout !== 8'h5A || n_start - s0 != 1 || n_stop - p0 != 1) begin miscompares++;
      $display("FAIL rm_after: acks=%b dout=%h start=%0d stop=%0d, required 11/5a/1/1", {a1, a2}, last_dout, n_start - s0, n_stop - p0); end
  endtask

  task automatic test_glitch();
    int s0 = n_start, p0 = n_stop, d0 = n_dout;
    logic a1, a2;
    // Idle-bus glitch: both lines high, SDA dips for FILTER_LEN-1 cycles.
    m_sda_low = 1'b1; clks(FILTER_LEN - 1); m_sda_low = 1'b0; clks(Q);
    vectors++; if (n_start != s0 || busy !== 1'b0) begin miscompares++; $display("FAIL gl_idle: start=%0d busy=%b, required 0/0", n_start - s0, busy); end
    // Mid-byte glitch while SCL is high on a data '1'.
    bus_start(); wr_byte(8'h84, -1, a1); wr_byte(8'hFF, 3, a2);
    vectors++; if ({a1, a2} !== 2'b11 || last_dout !== 8'hFF || n_dout - d0 != 1) begin miscompares++;
      $display("FAIL gl_data: acks=%b dout=%h n=%0d, required 11/ff/1", {a1, a2}, last_dout, n_dout - d0); end
    vectors++; if (n_start - s0 != 1 || n_stop != p0 || busy !== 1'b1) begin miscompares++;
      $display("FAIL gl_cond: start=%0d stop=%0d busy=%b, required 1/0/1", n_start - s0, n_stop - p0, busy); end
    bus_stop();
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int s0 = n_start, p0 = n_stop, d0 = n_dout;
      logic [7:0] a, d;
      logic a1, a2, exp_a;
      if ($urandom_range(0, 1) == 1) a = 8'h84;
      else begin a = 8'($urandom) & 8'hFE; while (a[7:1] == SLAVE_ADDR) a = 8'($urandom) & 8'hFE; end
      d = 8'($urandom); sendAck = 1'($urandom_range(0, 1)); exp_a = model_addr_ack(a);
      bus_start(); wr_byte(a, -1, a1); wr_byte(d, -1, a2); bus_stop();
      vectors++; if ({a1, a2} !== {exp_a, exp_a & sendAck}) begin miscompares++;
        $display("FAIL rnd_acks[%0d]: addr %h got %b, required %b", it, a, {a1, a2}, {exp_a, exp_a & sendAck}); end
      vectors++; if (n_dout - d0 != int'(exp_a) || n_start - s0 != int'(exp_a) || n_stop - p0 != int'(exp_a)) begin miscompares++;
        $display("FAIL rnd_strobes[%0d]: dout/start/stop %0d/%0d/%0d, required %0d each", it, n_dout - d0, n_start - s0, n_stop - p0, exp_a); end
      vectors++; if (exp_a && last_dout !== d) begin miscompares++; $display("FAIL rnd_dout[%0d]: got %h, required %h", it, last_dout, d); end
    end
    sendAck = 1'b1;
    for (int it = 0; it < 2; it++) begin
      logic [7:0] v, d;
      logic a1;
      v = 8'($urandom);
      bus_start(); wr_byte(8'h85, -1, a1);
      fork
        fabric($urandom_range(0, 20), v);
        rd_byte(1'b0, d);
      join
      bus_stop();
      vectors++; if (d !== v || a1 !== 1'b1 || recvAck !== 1'b0) begin miscompares++;
        $display("FAIL rnd_read[%0d]: data %h ack %b recv %b, required %h/1/0", it, d, a1, recvAck, v); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_bad_address();
    test_read_nack();
    test_write_nack();
    test_restart_read();
    test_reset_mid_stretch();
    test_glitch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
